dm_access_ctrl: RTL and testbench

//  Sequencer between the rv32i load/store stage and the word-wide data memory DM.
//  - DM has a combinational read and writes on posedge when we=1. It only stores whole words.
//  - This block turns byte/half/word loads and stores into DM word accesses:

---
 rtl/dm_access_ctrl_pkg.sv | 39 +++
 rtl/dm_access_ctrl_lane_unit.sv | 40 ++++
 rtl/dm_access_ctrl.sv | 118 +++++++++++
 tb/tb_dm_access_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_access_ctrl_pkg.sv
// Shared definitions for the data-memory access sequencer: funct3 codes,
// FSM state encoding, default DM depth and the access fault rule.
package dm_access_ctrl_pkg;

  localparam int unsigned DM_WORDS_DEF = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WRITE,
    ST_RMW_RD,
    ST_RMW_WR,
    ST_RESP,
    ST_ERR
  } state_t;

  function automatic logic access_fault(input logic        we,
                                        input logic [2:0]  f3,
                                        input logic [31:0] addr,
                                        input int unsigned words);
    logic illegal;
    logic misal;
    logic oob;
    if (we) illegal = !(f3 == F3_B || f3 == F3_H || f3 == F3_W);
    else    illegal = !(f3 == F3_B || f3 == F3_H || f3 == F3_W ||
                        f3 == F3_BU || f3 == F3_HU);
    misal = ((f3 == F3_H || f3 == F3_HU) && addr[0]) ||
            (f3 == F3_W && addr[1:0] != 2'b00);
    oob   = {2'b00, addr[31:2]} >= words;
    return illegal | misal | oob;
  endfunction

endpackage

// File: rtl/dm_access_ctrl_lane_unit.sv
// Byte/half lane handling for word-wide DM: load extraction with sign/zero
// extension and store-data merge for read-modify-write.
module dm_lane_unit
  import dm_access_ctrl_pkg::*;
(
  input  logic [31:0] i_rd,
  input  logic [15:0] i_wdata,
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_f3,
  output logic [31:0] o_extract,
  output logic [31:0] o_merge
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_rd[{i_off, 3'b000} +: 8];
  assign w_half = i_rd[{i_off[1], 4'b0000} +: 16];

  always_comb begin
    o_extract = i_rd;
    case (i_f3)
      F3_B:    o_extract = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_extract = {24'h0, w_byte};
      F3_H:    o_extract = {{16{w_half[15]}}, w_half};
      F3_HU:   o_extract = {16'h0, w_half};
      default: o_extract = i_rd;
    endcase
  end

  always_comb begin
    o_merge = i_rd;
    case (i_f3)
      F3_B:    o_merge[{i_off, 3'b000} +: 8]     = i_wdata[7:0];
      F3_H:    o_merge[{i_off[1], 4'b0000} +: 16] = i_wdata;
      default: o_merge = i_rd;
    endcase
  end

endmodule

// File: rtl/dm_access_ctrl.sv
// Sequencer turning RV32I byte/half/word loads and stores into word accesses
// on a combinational-read DM, with RMW for sub-word stores and fault reporting.
// IDLE: wait for request | LOAD: sample DM, extract | WRITE: SW write cycle
// RMW_RD: read + merge   | RMW_WR: write merged word | ERR: flag fault | RESP: pulse
module dm_access_ctrl
  import dm_access_ctrl_pkg::*;
#(
  parameter int unsigned DM_WORDS = DM_WORDS_DEF,
  parameter int unsigned IDX_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [2:0]       req_funct3,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  output logic             resp_valid,
  output logic [31:0]      resp_rdata,
  output logic             resp_err,
  output logic [IDX_W-1:0] dm_addr,
  output logic [31:0]      dm_wd,
  output logic             dm_we,
  input  logic [31:0]      dm_rd
);

  state_t      r_state;
  logic        r_req_ready;
  logic        r_resp_valid;
  logic        r_resp_err;
  logic [31:0] r_resp_rdata;
  logic [31:0] r_addr;
  logic [31:0] r_dm_wd;
  logic [2:0]  r_f3;
  logic [15:0] r_wdata;

  logic        w_accept;
  logic        w_fault;
  logic [31:0] w_extract;
  logic [31:0] w_merge;

  assign w_accept = req_valid & r_req_ready;
  assign w_fault  = access_fault(req_we, req_funct3, req_addr, DM_WORDS);

  dm_lane_unit u_lane (
    .i_rd      (dm_rd),
    .i_wdata   (r_wdata),
    .i_off     (r_addr[1:0]),
    .i_f3      (r_f3),
    .o_extract (w_extract),
    .o_merge   (w_merge)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= 32'h0;
      r_addr       <= 32'h0;
      r_dm_wd      <= 32'h0;
      r_f3         <= 3'b000;
      r_wdata      <= 16'h0;
    end else begin
      r_resp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_req_ready  <= 1'b0;
            r_resp_rdata <= 32'h0;
            r_resp_err   <= 1'b0;
            r_addr       <= req_addr;
            r_f3         <= req_funct3;
            r_wdata      <= req_wdata[15:0];
            if (w_fault)                   r_state <= ST_ERR;
            else if (!req_we)              r_state <= ST_LOAD;
            else if (req_funct3 == F3_W) begin
              r_dm_wd <= req_wdata;
              r_state <= ST_WRITE;
            end else                       r_state <= ST_RMW_RD;
          end
        end
        ST_LOAD: begin
          r_resp_rdata <= w_extract;
          r_state      <= ST_RESP;
        end
        ST_WRITE:  r_state <= ST_RESP;
        ST_RMW_RD: begin
          r_dm_wd <= w_merge;
          r_state <= ST_RMW_WR;
        end
        ST_RMW_WR: r_state <= ST_RESP;
        ST_ERR: begin
          r_resp_err <= 1'b1;
          r_state    <= ST_RESP;
        end
        ST_RESP: begin
          r_resp_valid <= 1'b1;
          r_req_ready  <= 1'b1;
          r_state      <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Write strobe comes straight from the state register so reset kills it at once.
  assign dm_we      = (r_state == ST_WRITE) || (r_state == ST_RMW_WR);
  assign dm_addr    = IDX_W'(r_addr[31:2]);
  assign dm_wd      = r_dm_wd;
  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Self-checking bench for dm_access_ctrl: directed scenarios plus random
// loads/stores against a word-array reference model with its own fault rules.
module tb_dm_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] dm_addr;
  logic [31:0] dm_wd;
  logic        dm_we;
  logic [31:0] dm_rd;

  logic [31:0] mem     [32];
  logic [31:0] ref_mem [32];
  logic        load_mem;

  int n_cmp  = 0;
  int n_fail = 0;
  int we_cnt = 0;
  int rv_cnt = 0;
  logic [31:0] we_addr = 32'h0;

  always #5 clk = ~clk;

  dm_access_ctrl #(.DM_WORDS(32), .IDX_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .dm_addr    (dm_addr),
    .dm_wd      (dm_wd),
    .dm_we      (dm_we),
    .dm_rd      (dm_rd)
  );

  assign dm_rd = mem[dm_addr[4:0]];

  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < 32; i++) mem[i] <= ref_mem[i];
    end else if (dm_we) begin
      mem[dm_addr[4:0]] <= dm_wd;
    end
  end

  always @(negedge clk) begin
    if (dm_we) begin
      we_cnt++;
      we_addr = dm_addr;
    end
    if (resp_valid) rv_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: plain word-array arithmetic, applied at accept time.
  function automatic void ref_access(input logic we, input logic [2:0] f3,
                                     input logic [31:0] addr, input logic [31:0] wd,
                                     output logic err, output logic [31:0] rd,
                                     output int lat, output int nwe);
    logic [31:0] idx, w, val, mask;
    int off, size;
    bit legal;
    idx  = addr >> 2;
    off  = int'(addr % 4);
    size = int'(f3) % 4;
    legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    err = !legal || (size == 1 && (addr % 2) != 0) || (size == 2 && off != 0) || idx >= 32;
    rd  = 32'h0;
    lat = 2;
    nwe = 0;
    if (err) return;
    w = ref_mem[idx[4:0]];
    if (!we) begin
      val = w >> (8 * off);
      if (size == 0) begin
        val = val & 32'hFF;
        if (f3 < 3'd4 && val >= 32'h80) val = val | 32'hFFFFFF00;
      end else if (size == 1) begin
        val = val & 32'hFFFF;
        if (f3 < 3'd4 && val >= 32'h8000) val = val | 32'hFFFF0000;
      end
      rd = val;
    end else begin
      nwe = 1;
      if (size == 2) begin
        ref_mem[idx[4:0]] = wd;
      end else begin
        mask = ((size == 0) ? 32'hFF : 32'hFFFF) << (8 * off);
        ref_mem[idx[4:0]] = (w & ~mask) | ((wd << (8 * off)) & mask);
        lat = 3;
      end
    end
  endfunction

  task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input string tag, output logic [31:0] rd_o);
    logic        e_err;
    logic [31:0] e_rd;
    int e_lat, e_nwe, we0, rv0, lat;
    bit got;
    ref_access(we, f3, addr, wd, e_err, e_rd, e_lat, e_nwe);
    we0 = we_cnt;
    rv0 = rv_cnt;
    @(negedge clk);
    check({tag, "_ready"}, 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_we     = 1'($urandom_range(0, 1));
    req_funct3 = 3'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
    lat = 0;
    got = 0;
    while (!got && lat < 8) begin
      @(posedge clk);
      #1;
      lat++;
      got = resp_valid;
    end
    check({tag, "_lat"}, 32'(lat), 32'(e_lat));
    check({tag, "_rdata"}, resp_rdata, e_rd);
    check({tag, "_err"}, 32'(resp_err), 32'(e_err));
    rd_o = resp_rdata;
    @(posedge clk);
    #1;
    check({tag, "_pulse"}, 32'(resp_valid), 32'd0);
    check({tag, "_nresp"}, 32'(rv_cnt - rv0), 32'd1);
    check({tag, "_nwe"}, 32'(we_cnt - we0), 32'(e_nwe));
    if (e_nwe != 0) check({tag, "_weaddr"}, we_addr, addr >> 2);
  endtask

  initial begin
    logic [31:0] rd, e_rd1, e_rd2, saved;
    logic        e_err;
    int          e_lat, e_nwe, rv0, we0;

    rst = 1'b1;
    load_mem = 1'b1;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_funct3 = 3'b000;
    req_addr = 32'h0;
    req_wdata = 32'h0;
    for (int i = 0; i < 32; i++) ref_mem[i] = $urandom;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_rvalid", 32'(resp_valid), 32'd0);
    check("rst_rdata", resp_rdata, 32'h0);
    check("rst_err", 32'(resp_err), 32'd0);
    check("rst_we", 32'(dm_we), 32'd0);
    check("rst_addr", dm_addr, 32'h0);
    check("rst_wd", dm_wd, 32'h0);
    load_mem = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    run_op(1'b1, 3'b010, 32'h8, 32'hDEADBEEF, "t1_sw", rd);
    run_op(1'b0, 3'b010, 32'h8, 32'h0, "t1_lw", rd);
    check("t1_lw_val", rd, 32'hDEADBEEF);

    run_op(1'b1, 3'b000, 32'h9, 32'h55, "t2_sb", rd);
    check("t2_word2", mem[2], 32'hDEAD55EF);
    run_op(1'b0, 3'b000, 32'h9, 32'h0, "t2_lb9", rd);
    check("t2_lb9_val", rd, 32'h00000055);
    run_op(1'b0, 3'b000, 32'hB, 32'h0, "t2_lbb", rd);
    check("t2_lbb_val", rd, 32'hFFFFFFDE);
    run_op(1'b0, 3'b100, 32'hB, 32'h0, "t2_lbub", rd);
    check("t2_lbub_val", rd, 32'h000000DE);

    run_op(1'b1, 3'b010, 32'h8, 32'hDEADBEEF, "t3_sw", rd);
    run_op(1'b1, 3'b001, 32'hA, 32'h1234, "t3_sh", rd);
    check("t3_word2", mem[2], 32'h1234BEEF);
    run_op(1'b0, 3'b001, 32'h8, 32'h0, "t3_lh", rd);
    check("t3_lh_val", rd, 32'hFFFFBEEF);
    run_op(1'b0, 3'b101, 32'h8, 32'h0, "t3_lhu", rd);
    check("t3_lhu_val", rd, 32'h0000BEEF);

    run_op(1'b0, 3'b010, 32'h6, 32'h0, "t4_lw6", rd);
    run_op(1'b1, 3'b001, 32'h3, 32'hFFFF, "t4_sh3", rd);
    run_op(1'b0, 3'b000, 32'h80, 32'h0, "t4_lb80", rd);
    run_op(1'b1, 3'b100, 32'h0, 32'h12345678, "t4_sf3", rd);
    check("t4_word0", mem[0], ref_mem[0]);
    check("t4_word1", mem[1], ref_mem[1]);

    // Handshake with req_valid held high across two requests.
    rv0 = rv_cnt;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h8; req_wdata = 32'h0;
    ref_access(1'b0, 3'b010, 32'h8, 32'h0, e_err, e_rd1, e_lat, e_nwe);
    @(posedge clk);
    #1;
    req_funct3 = 3'b000; req_addr = 32'h9;
    @(negedge clk);
    check("t5_rdy_c1", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("t5_rdy_c2", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("t5_rv_c3", 32'(resp_valid), 32'd1);
    check("t5_rdy_c3", 32'(req_ready), 32'd1);
    check("t5_rd1", resp_rdata, e_rd1);
    @(posedge clk);
    ref_access(1'b0, 3'b000, 32'h9, 32'h0, e_err, e_rd2, e_lat, e_nwe);
    #1;
    req_valid = 1'b0;
    check("t5_rdy_acc2", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    check("t5_rv_e1", 32'(resp_valid), 32'd0);
    @(posedge clk);
    #1;
    check("t5_rv_e2", 32'(resp_valid), 32'd1);
    check("t5_rd2", resp_rdata, e_rd2);
    @(posedge clk);
    #1;
    check("t5_nresp", 32'(rv_cnt - rv0), 32'd2);

    // Reset during RMW_RD of SB 0x4.
    rv0 = rv_cnt;
    we0 = we_cnt;
    saved = ref_mem[1];
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h4; req_wdata = 32'hAA;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("t6_rst_ready", 32'(req_ready), 32'd1);
    check("t6_rst_we", 32'(dm_we), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("t6_word1", mem[1], saved);
    check("t6_nresp", 32'(rv_cnt - rv0), 32'd0);
    check("t6_nwe", 32'(we_cnt - we0), 32'd0);
    run_op(1'b0, 3'b010, 32'h4, 32'h0, "t6_lw", rd);
    check("t6_lw_val", rd, saved);

    // Reset during WRITE of SW 0x10: the strobe must drop before the edge.
    we0 = we_cnt;
    saved = ref_mem[4];
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h10; req_wdata = 32'hA5A5A5A5;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("t7_we_hi", 32'(dm_we), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check("t7_we_drop", 32'(dm_we), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("t7_word4", mem[4], saved);
    check("t7_nwe", 32'(we_cnt - we0), 32'd0);

    for (int n = 0; n < 200; n++) begin
      logic        r_we_t;
      logic [2:0]  r_f3_t;
      logic [31:0] r_addr_t;
      r_we_t = 1'($urandom_range(0, 1));
      r_f3_t = 3'($urandom_range(0, 7));
      r_addr_t = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 135));
      run_op(r_we_t, r_f3_t, r_addr_t, $urandom, "rnd", rd);
    end

    for (int i = 0; i < 32; i++) check($sformatf("mem_%0d", i), mem[i], ref_mem[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
